pipo_rr_arbiter: RTL
====================

// Module: pipo_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one WIDTH-bit parallel-in/parallel-out data register among NREQ requesters.
//   Chooses one requester per grant and loads that requester's data word into the register.
//   Holds the grant and the register contents for HOLD_CYCLES cycles.
//   Sits between multiple producers and a single downstream consumer of the registered word.
// PARAMETERS
//   WIDTH        4   data word width, >=1
//   NREQ         4   number of requesters, 2..16
//   HOLD_CYCLES  2   cycles a grant and the loaded word are held, >=1
// PORTS
//   clk         in   1           rising-edge clock
//   rst_n       in   1           asynchronous, active-low reset
//   req         in   NREQ        request per requester, level
//   d_in        in   NREQ*WIDTH  flat data; requester i occupies d_in[i*WIDTH +: WIDTH]
//   gnt         out  NREQ        one-hot grant, registered
//   gnt_id      out  ID_W        index of granted requester; ID_W = $clog2(NREQ)
//   d_out       out  WIDTH       shared register contents
//   d_valid     out  1           one-cycle pulse when d_out is loaded
//   grant_cnt   out  NREQ*8      per-requester grant counters (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, gnt=0, gnt_id=0, d_out=0, d_valid=0, ptr=0, cnt=0, grant_cnt=0.
//   Arbitration: winner = first i with req[i]=1, searching ptr, ptr+1, ... NREQ-1, 0, ... ptr-1.
//   FSM states:
//     IDLE: if |req, at the edge: gnt<=onehot(winner), gnt_id<=winner, d_out<=d_in[winner],
//           d_valid<=1, ptr<=(winner+1) mod NREQ, cnt<=HOLD_CYCLES-1, next state HOLD.
//           Otherwise gnt=0 and d_out retains its value.
//     HOLD: d_valid<=0; gnt, gnt_id and d_out stay stable.
//           If cnt!=0: cnt<=cnt-1.
//           If cnt==0 and |req: re-arbitrate back-to-back, same actions as IDLE load.
//           If cnt==0 and no req: gnt<=0, next state IDLE.
//   Latency: req sampled high at edge N gives gnt and d_out valid after edge N.
//     The grant then lasts exactly HOLD_CYCLES cycles.
//   HOLD_CYCLES=1: a new winner loads on every cycle while requests are pending.
//   Request dropped during HOLD: ignored; the grant runs its full duration.
//   Request dropped before being granted: that requester is not considered.
//   d_in of the winner is sampled only on the load edge; later changes are ignored.
//   ptr wrap: after granting NREQ-1, the search restarts at 0.
//   Reset asserted mid-HOLD: all outputs clear immediately; the in-flight grant is lost, no pulse.
//   Never more than one gnt bit set. d_valid only asserts together with a new gnt.
// CONFIGURATION
//   ARB_STATS_EN defined:
//     grant_cnt[i*8 +: 8] increments on each load granted to requester i.
//     Counters saturate at 8'hFF and clear only on reset.
//   ARB_STATS_EN undefined:
//     grant_cnt is tied to 0; no counter flops are built.
// STRUCTURE
//   Shared package file pipo_arb_pkg:
//     state encodings ST_IDLE=1'b0, ST_HOLD=1'b1
//     STAT_W=8, STAT_MAX=8'hFF
//   Sub-module pipo_rr_pick (combinational):
//     inputs req and ptr; outputs winner index and any_req.
//     Implemented as a rotate, fixed-priority pick, then un-rotate.
//   Top level holds the FSM, ptr, cnt, the data register and the optional counters.
// TESTING (WIDTH=4, NREQ=4, HOLD_CYCLES=2)
//   1. Reset: rst_n=0 with req=1111 -> gnt=0000, d_out=0000, d_valid=0, grant_cnt=0.
//   2. Single request: req=0010, d_in[1]=1101
//      -> after next edge gnt=0010, gnt_id=1, d_out=1101, d_valid=1 for 1 cycle
//      -> gnt=0010 held 2 cycles, then 0000; d_out stays 1101.
//   3. Full contention: req=1111, words 0001/0010/0100/1000
//      -> gnt 0001,0010,0100,1000,0001..., each held 2 cycles, back-to-back, no idle gap
//      -> d_out follows the granted word; one d_valid pulse per grant.
//   4. Wrap: after a grant to requester 3, req=1001 -> next gnt=0001 (ptr wrapped to 0), not 1000.
//   5. Reset mid-HOLD: drop rst_n during the 2nd hold cycle -> gnt=0000, d_out=0000 asynchronously
//      -> after release, req=0100 -> gnt=0100 (ptr restarted at 0).
//   6. ARB_STATS_EN: 300 grants to requester 0 -> grant_cnt[7:0]=8'hFF saturated, others unchanged.
//      Without the macro: grant_cnt=0 throughout.

Source files
------------

// File: rtl/pipo_arb_pkg.sv
// pipo_arb_pkg: shared state encodings and statistics constants for pipo_rr_arbiter.
package pipo_arb_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;
    localparam int STAT_W = 8;
    localparam logic [STAT_W-1:0] STAT_MAX = 8'hFF;
endpackage

// File: rtl/pipo_rr_pick.sv
// pipo_rr_pick: round-robin winner search starting at ptr (rotate, fixed-priority pick, un-rotate).
module pipo_rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner,
    output logic            any_req
);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [ID_W-1:0]   off;
    logic [ID_W:0]     sum;

    assign dbl     = {req, req} >> ptr;
    assign rot     = dbl[NREQ-1:0];
    assign any_req = |req;

    always_comb begin
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rot[i]) off = ID_W'(i);
        sum    = {1'b0, ptr} + {1'b0, off};
        winner = (sum >= (ID_W+1)'(NREQ)) ? ID_W'(sum - (ID_W+1)'(NREQ)) : sum[ID_W-1:0];
    end
endmodule

// File: rtl/pipo_rr_arbiter.sv
// pipo_rr_arbiter: round-robin arbiter loading the winner's word into a shared register held HOLD_CYCLES cycles.
// Define ARB_STATS_EN to build saturating per-requester grant counters.
module pipo_rr_arbiter
    import pipo_arb_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    d_in,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic [WIDTH-1:0]         d_out,
    output logic                     d_valid,
    output logic [NREQ*STAT_W-1:0]   grant_cnt
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  winner;
    logic [CNT_W-1:0] cnt;
    logic             any_req;
    logic             load;

    pipo_rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // A new grant starts from IDLE or back-to-back once the current hold expires.
    assign load = any_req && (state == ST_IDLE || cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            d_out   <= '0;
            d_valid <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            d_valid <= load;
            if (load) begin
                state  <= ST_HOLD;
                gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
                gnt_id <= winner;
                d_out  <= d_in[winner*WIDTH +: WIDTH];
                ptr    <= (winner == ID_W'(NREQ-1)) ? '0 : winner + 1'b1;
                cnt    <= CNT_W'(HOLD_CYCLES-1);
            end else if (state == ST_HOLD && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                state <= ST_IDLE;
                gnt   <= '0;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [NREQ*STAT_W-1:0] stats;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stats <= '0;
        end else if (load) begin
            for (int i = 0; i < NREQ; i++)
                if (winner == ID_W'(i) && stats[i*STAT_W +: STAT_W] != STAT_MAX)
                    stats[i*STAT_W +: STAT_W] <= stats[i*STAT_W +: STAT_W] + 1'b1;
        end
    end

    assign grant_cnt = stats;
`else
    assign grant_cnt = '0;
`endif
endmodule
